// File: rtl/qos_arb_pkg.sv
// qos_arb_pkg: shared sizes, arbitration mode encodings and FSM state type
package qos_arb_pkg;
  localparam int N_REQ = 4;
  localparam int TBL_DEPTH = 16;
  typedef enum logic [1:0] {
    MODE_RR     = 2'b00,
    MODE_TABLE  = 2'b01,
    MODE_WRR    = 2'b10,
    MODE_STRICT = 2'b11
  } mode_e;
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority pick of the first requester at or after start
module rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] start,
  output logic [1:0] winner,
  output logic       found
);
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[start + 2'(k)]) begin
        winner = start + 2'(k);
        found  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/vc_arb_scheduler.sv
// vc_arb_scheduler: packet-granular 4-way arbiter with RR, TABLE, WRR and STRICT modes
module vc_arb_scheduler
  import qos_arb_pkg::*;
#(
  parameter int N_REQ = qos_arb_pkg::N_REQ,
  parameter int TBL_DEPTH = qos_arb_pkg::TBL_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enb,
  input  logic [1:0]                   mode,
  input  logic [N_REQ-1:0]             req,
  input  logic [2*N_REQ-1:0]           weight,
  input  logic                         done,
  input  logic                         tbl_we,
  input  logic [$clog2(TBL_DEPTH)-1:0] tbl_addr,
  input  logic [1:0]                   tbl_data,
  output logic [N_REQ-1:0]             gnt,
  output logic                         gnt_valid,
  output logic [$clog2(TBL_DEPTH)-1:0] tbl_ptr
);
  localparam int AW = $clog2(TBL_DEPTH);
  state_e state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [1:0] last_q, last_d, credit_q, credit_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [1:0] tbl_q [TBL_DEPTH];
  logic [1:0] tbl_d [TBL_DEPTH];
  logic [1:0] rr_win, st_win, win, tbl_ent;
  logic rr_found, st_found, found, stay;
  rr_pick u_rr (.req(req), .start(last_q + 2'd1), .winner(rr_win), .found(rr_found));
  rr_pick u_st (.req(req), .start(2'd0), .winner(st_win), .found(st_found));
  assign tbl_ent = tbl_q[ptr_q];
  assign stay = mode == MODE_WRR && req[last_q] && credit_q < weight[2*last_q +: 2];
  always_comb begin
    win = mode == MODE_STRICT ? st_win : mode == MODE_TABLE ? tbl_ent : stay ? last_q : rr_win;
    found = mode == MODE_STRICT ? st_found : mode == MODE_TABLE ? req[tbl_ent] : stay || rr_found;
    state_d = state_q;
    gnt_d = gnt_q;
    last_d = last_q;
    credit_d = credit_q;
    ptr_d = ptr_q;
    tbl_d = tbl_q;
    if (tbl_we) tbl_d[tbl_addr] = tbl_data;
    if (state_q == IDLE) begin
      if (enb && mode == MODE_TABLE) ptr_d = ptr_q + 1'b1;
      if (enb && found) begin
        state_d = GRANT;
        gnt_d = '0;
        gnt_d[win] = 1'b1;
        last_d = win;
        credit_d = stay ? credit_q + 2'd1 : 2'd0;
      end
    end else if (done) begin
      state_d = IDLE;
      gnt_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q <= '0;
      last_q <= 2'd3;
      credit_q <= '0;
      ptr_q <= '0;
      for (int i = 0; i < TBL_DEPTH; i++) tbl_q[i] <= 2'(i);
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      last_q <= last_d;
      credit_q <= credit_d;
      ptr_q <= ptr_d;
      tbl_q <= tbl_d;
    end
  end
  assign gnt = gnt_q;
  assign gnt_valid = |gnt_q;
  assign tbl_ptr = ptr_q;
endmodule

// File: tb/tb_vc_arb_scheduler.sv
// tb_vc_arb_scheduler: randomized and directed checks against a cycle-level reference model
module tb_vc_arb_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enb = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] req = 4'd0;
  logic [7:0] weight = 8'd0;
  logic done = 1'b0;
  logic tbl_we = 1'b0;
  logic [3:0] tbl_addr = 4'd0;
  logic [1:0] tbl_data = 2'd0;
  logic [3:0] gnt;
  logic gnt_valid;
  logic [3:0] tbl_ptr;
  int n_tests = 0;
  int n_fail = 0;
  int m_busy, m_owner, m_last, m_credit, m_ptr, m_prev_ptr;
  int m_tbl [16];
  vc_arb_scheduler dut (
    .clk(clk), .rst(rst), .enb(enb), .mode(mode), .req(req), .weight(weight),
    .done(done), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .gnt(gnt), .gnt_valid(gnt_valid), .tbl_ptr(tbl_ptr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, want);
    end
  endtask
  function automatic int rr_search(input int after);
    for (int o = 1; o <= 4; o++) if (req[(after + o) % 4]) return (after + o) % 4;
    return -1;
  endfunction
  function automatic void model_step();
    int w;
    bit again;
    w = -1;
    again = 0;
    m_prev_ptr = m_ptr;
    if (rst) begin
      m_busy = 0; m_last = 3; m_credit = 0; m_ptr = 0;
      for (int i = 0; i < 16; i++) m_tbl[i] = i % 4;
      return;
    end
    if (!m_busy) begin
      if (enb) begin
        case (mode)
          2'd0: w = rr_search(m_last);
          2'd3: w = rr_search(3);
          2'd2: begin
            if (req[m_last] && m_credit < ((weight >> (2 * m_last)) & 3)) begin
              w = m_last;
              again = 1;
            end else w = rr_search(m_last);
          end
          default: begin
            if (req[m_tbl[m_ptr]]) w = m_tbl[m_ptr];
            m_ptr = (m_ptr + 1) % 16;
          end
        endcase
        if (w >= 0) begin
          m_busy = 1;
          m_owner = w;
          m_last = w;
          m_credit = again ? m_credit + 1 : 0;
        end
      end
    end else if (done) m_busy = 0;
    if (tbl_we) m_tbl[tbl_addr] = tbl_data;
  endfunction
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("gnt", gnt, m_busy ? (32'd1 << m_owner) : 32'd0);
    chk("gnt_valid", gnt_valid, m_busy);
    chk("tbl_ptr", tbl_ptr, m_ptr);
    if (m_prev_ptr == 15 && m_ptr == 0) chk("ptr_wrap", tbl_ptr, 0);
  endtask
  task automatic do_reset();
    rst = 1'b1; done = 1'b1; tbl_we = 1'b1;
    step();
    chk("rst_gnt", gnt, 0);
    chk("rst_ptr", tbl_ptr, 0);
    rst = 1'b0; done = 1'b0; tbl_we = 1'b0;
  endtask
  task automatic wait_grant(input string tag, input logic [3:0] want);
    int n = 0;
    while (!gnt_valid && n < 10) begin
      step();
      n++;
    end
    chk(tag, gnt, want);
  endtask
  task automatic release_after(input int n);
    repeat (n - 1) step();
    done = 1'b1;
    step();
    done = 1'b0;
  endtask
  initial begin
    logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] wrr_exp [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0001};
    int n;
    do_reset();
    mode = 2'd0; req = 4'b1111; enb = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_grant("rr_seq", rr_exp[k]);
      release_after(3);
    end
    do_reset();
    mode = 2'd2; weight = 8'b00_00_00_10; req = 4'b0011;
    for (int k = 0; k < 7; k++) begin
      wait_grant("wrr_seq", wrr_exp[k]);
      release_after(1);
    end
    do_reset();
    enb = 1'b0; tbl_we = 1'b1; tbl_addr = 4'd1; tbl_data = 2'd2;
    step();
    tbl_we = 1'b0; mode = 2'd1; req = 4'b0001; enb = 1'b1;
    wait_grant("tbl_first", 4'b0001);
    done = 1'b1;
    repeat (40) step();
    done = 1'b0;
    do_reset();
    mode = 2'd3; req = 4'b1010;
    wait_grant("strict_first", 4'b0010);
    req = 4'b1000;
    step(); step();
    chk("strict_hold", gnt, 4'b0010);
    release_after(1);
    wait_grant("strict_next", 4'b1000);
    rst = 1'b1;
    step();
    chk("rst_abort", gnt, 0);
    rst = 1'b0; mode = 2'd0; req = 4'b1111; enb = 1'b0;
    repeat (4) step();
    chk("enb_block", gnt_valid, 0);
    done = 1'b1;
    step();
    done = 1'b0;
    enb = 1'b1;
    wait_grant("rr_after_rst", 4'b0001);
    release_after(1);
    do_reset();
    mode = 2'd1; req = 4'b0001; enb = 1'b1; tbl_we = 1'b1; tbl_addr = 4'd0; tbl_data = 2'd3;
    step();
    chk("tbl_old_entry", gnt, 4'b0001);
    tbl_we = 1'b0; done = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (tbl_ptr != 4'd0 && n < 60);
    chk("tbl_ptr_return", tbl_ptr, 0);
    step();
    chk("tbl_new_entry", gnt, 0);
    done = 1'b0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(99) == 0);
      enb = ($urandom_range(9) != 0);
      mode = 2'($urandom);
      req = 4'($urandom);
      weight = 8'($urandom);
      done = ($urandom_range(2) == 0);
      tbl_we = ($urandom_range(4) == 0);
      tbl_addr = 4'($urandom);
      tbl_data = 2'($urandom);
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
